// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one write port and one registered read port.
// With ENABLE_BYPASS, a read of the address being written in the same cycle
// returns the new data. dout holds its value while re is low.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1,
  parameter int CLEAR_ON_INIT = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port: store din at waddr when we is high.
  // NOTE: the storage array has no reset so it maps onto RAM macros; reset
  // only the bookkeeping around it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  generate
    if (ENABLE_BYPASS != 0) begin : g_bypass
      // Read port with write-first forwarding on an address collision.
      always_ff @(posedge clk) begin
        if (re) dout <= (we && (waddr == raddr)) ? din : mem[raddr];
      end
    end else begin : g_no_bypass
      // Read port returning the old contents on an address collision.
      always_ff @(posedge clk) begin
        if (re) dout <= mem[raddr];
      end
    end

    // Contents are never cleared in hardware; the parameter is kept so that
    // instantiations shared with simulation-only variants stay compatible.
    if (CLEAR_ON_INIT != 0) begin : g_clear_on_init_unsupported
    end
  endgenerate

endmodule

// File: rtl/mor1kx_dpram_fifo.sv
// First-word-fall-through FIFO wrapped around a simple dual-port RAM.
// The head entry sits in the RAM output register; head_valid tracks whether
// that register holds a live entry, so the RAM latency never shows up as a bubble.
module mor1kx_dpram_fifo #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic                   full_o,
  input  logic                   rd_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   empty_o,
  output logic [DEPTH_WIDTH:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DEPTH_WIDTH:0] wr_ptr;
  logic [DEPTH_WIDTH:0] rd_ptr;
  logic [DEPTH_WIDTH:0] count;
  logic                 head_valid;

  logic wr_en;
  logic rd_en;
  logic unfetched;
  logic can_load;
  logic ram_re;

  assign wr_en     = wr_i & ~full_o;
  assign rd_en     = rd_i & head_valid;
  // rd_ptr counts entries already fetched into the output register, so any
  // pointer difference means the RAM still holds entries behind the head.
  assign unfetched = (wr_ptr != rd_ptr);
  assign can_load  = ~head_valid | rd_en;
  // A write landing this cycle can be fetched at once through the RAM bypass.
  assign ram_re    = can_load & (unfetched | wr_en);

  assign empty_o = ~head_valid;
  assign count_o = count;
  assign full_o  = (count == (DEPTH_WIDTH+1)'(DEPTH));

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1),
    .CLEAR_ON_INIT (0)
  ) u_ram (
    .clk   (clk),
    .raddr (rd_ptr[DEPTH_WIDTH-1:0]),
    .re    (ram_re),
    .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
    .we    (wr_en),
    .din   (wr_data_i),
    .dout  (rd_data_o)
  );

  // Pointer, occupancy and output-stage bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      if (ram_re) begin
        rd_ptr     <= rd_ptr + 1'b1;
        head_valid <= 1'b1;
      end else if (rd_en) begin
        head_valid <= 1'b0;
      end

      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

  a_count_bound : assert property (@(posedge clk)
    disable iff (rst) count_o <= (DEPTH_WIDTH+1)'(DEPTH));

  a_empty_count : assert property (@(posedge clk)
    disable iff (rst) empty_o |-> (count_o == '0));

  a_head_stable : assert property (@(posedge clk)
    (!rst && $past(!rst && head_valid && !rd_en)) |-> $stable(rd_data_o));

endmodule

// File: tb/tb_mor1kx_dpram_fifo.sv
// Self-checking bench for mor1kx_dpram_fifo: a queue scoreboard tracks the
// expected contents and an independent occupancy model tracks count/full/empty.
module tb_mor1kx_dpram_fifo;

  localparam int DW    = 4;
  localparam int DATAW = 32;
  localparam int DEPTH = 1 << DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_i;
  logic [DATAW-1:0]  wr_data_i;
  logic              full_o;
  logic              rd_i;
  logic [DATAW-1:0]  rd_data_o;
  logic              empty_o;
  logic [DW:0]       count_o;

  logic [DATAW-1:0]  sb [$];
  int                m_count;
  int                passed;
  int                total;

  always #5 clk = ~clk;

  mor1kx_dpram_fifo #(
    .DEPTH_WIDTH (DW),
    .DATA_WIDTH  (DATAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (wr_i),
    .wr_data_i (wr_data_i),
    .full_o    (full_o),
    .rd_i      (rd_i),
    .rd_data_o (rd_data_o),
    .empty_o   (empty_o),
    .count_o   (count_o)
  );

  // One clock cycle: compare the current outputs against the model, pop the
  // scoreboard on an accepted read, push on an accepted write, then clock.
  task automatic step(input logic wr, input logic [DATAW-1:0] data, input logic rd);
    logic [DATAW-1:0] exp;
    wr_i      = wr;
    wr_data_i = data;
    rd_i      = rd;
    total++;
    if (count_o !== (DW+1)'(m_count))
      $display("FAIL step_count: got %0d expected %0d", count_o, m_count);
    else passed++;
    total++;
    if (empty_o !== (m_count == 0))
      $display("FAIL step_empty: got %b expected %b", empty_o, m_count == 0);
    else passed++;
    total++;
    if (full_o !== (m_count == DEPTH))
      $display("FAIL step_full: got %b expected %b", full_o, m_count == DEPTH);
    else passed++;
    if (rd && m_count > 0) begin
      exp = sb.pop_front();
      total++;
      if (rd_data_o !== exp)
        $display("FAIL pop_data: got %h expected %h", rd_data_o, exp);
      else passed++;
    end
    if (wr && m_count < DEPTH) sb.push_back(data);
    m_count = sb.size();
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) step(1'b0, '0, 1'b1);
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty_o);
    else passed++;
    total++;
    if (full_o !== 1'b0) $display("FAIL reset_full: got %b expected 0", full_o);
    else passed++;
    total++;
    if (count_o !== '0) $display("FAIL reset_count: got %0d expected 0", count_o);
    else passed++;
  endtask

  task automatic test_first_write();
    step(1'b1, 32'hA5A5_0001, 1'b0);
    total++;
    if (empty_o !== 1'b0) $display("FAIL first_empty: got %b expected 0", empty_o);
    else passed++;
    total++;
    if (rd_data_o !== 32'hA5A5_0001)
      $display("FAIL first_data: got %h expected a5a50001", rd_data_o);
    else passed++;
    total++;
    if (count_o !== 5'd1) $display("FAIL first_count: got %0d expected 1", count_o);
    else passed++;
    drain();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATAW'(i), 1'b0);
    total++;
    if (full_o !== 1'b1 || count_o !== 5'd16)
      $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=16", full_o, count_o);
    else passed++;
    step(1'b1, 32'hDEAD, 1'b0);
    total++;
    if (count_o !== 5'd16) $display("FAIL fill_drop: got %0d expected 16", count_o);
    else passed++;
    drain();
    total++;
    if (empty_o !== 1'b1) $display("FAIL fill_empty: got %b expected 1", empty_o);
    else passed++;
  endtask

  task automatic test_wr_rd_count1();
    step(1'b1, 32'd6, 1'b0);
    step(1'b1, 32'd7, 1'b1);
    total++;
    if (rd_data_o !== 32'd7 || count_o !== 5'd1 || empty_o !== 1'b0)
      $display("FAIL count1_pass: got data=%h count=%0d empty=%b expected 7/1/0",
               rd_data_o, count_o, empty_o);
    else passed++;
    drain();
  endtask

  task automatic test_full_wr_rd();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + DATAW'(i), 1'b0);
    step(1'b1, 32'hDEAD, 1'b1);
    total++;
    if (count_o !== 5'd15 || full_o !== 1'b0)
      $display("FAIL full_wr_rd: got count=%0d full=%b expected 15/0", count_o, full_o);
    else passed++;
    drain();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5000 + DATAW'(i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom(), 1'b1);
      total++;
      if (count_o !== 5'd3 || empty_o !== 1'b0)
        $display("FAIL stream_level: got count=%0d empty=%b expected 3/0", count_o, empty_o);
      else passed++;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h900 + DATAW'(i), 1'b0);
    total++;
    if (count_o !== 5'd9) $display("FAIL mid_precount: got %0d expected 9", count_o);
    else passed++;
    apply_reset();
    total++;
    if (empty_o !== 1'b1 || count_o !== '0 || full_o !== 1'b0)
      $display("FAIL mid_reset: got empty=%b count=%0d full=%b expected 1/0/0",
               empty_o, count_o, full_o);
    else passed++;
    step(1'b1, 32'hCAFE_0042, 1'b0);
    total++;
    if (empty_o !== 1'b0 || rd_data_o !== 32'hCAFE_0042)
      $display("FAIL mid_rewrite: got empty=%b data=%h expected 0/cafe0042", empty_o, rd_data_o);
    else passed++;
    drain();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    m_count   = 0;
    rst       = 1'b1;
    wr_i      = 1'b0;
    rd_i      = 1'b0;
    wr_data_i = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_write();
    test_fill();
    test_wr_rd_count1();
    test_full_wr_rd();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mor1kx_dpram_fifo.md
# mor1kx_dpram_fifo

Single-clock first-word-fall-through FIFO that acts as the writer and reader in front of a simple dual-port RAM. It owns the write and read pointers, full/empty/count bookkeeping, and the one-cycle RAM read latency, so the head entry is always presented combinationally-stable on `rd_data_o`. Intended users are the store buffer and the bus-side queues in the LSU and fetch paths.

## Interface
Parameters:
- `DEPTH_WIDTH`, default 4: log2 of the number of entries (16 entries).
- `DATA_WIDTH`, default 32: entry width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_i`  in  1  write request.
- `wr_data_i`  in  DATA_WIDTH  data to write.
- `full_o`  out  1  no free entry; writes are ignored.
- `rd_i`  in  1  pop the head entry.
- `rd_data_o`  out  DATA_WIDTH  head entry; valid while `empty_o` = 0.
- `empty_o`  out  1  no entry presented.
- `count_o`  out  DEPTH_WIDTH+1  number of stored entries, 0..2^DEPTH_WIDTH.

## Operation
- The write and read pointers are DEPTH_WIDTH+1 bits wide. The low bits address the RAM; the MSB is the wrap bit.
- Write accepted = `wr_i & !full_o`. On acceptance, RAM `we`=1, `waddr`=wr_ptr, and wr_ptr increments modulo 2^(DEPTH_WIDTH+1).
- Read accepted = `rd_i & !empty_o`. When `empty_o`=1, `rd_i` is ignored with no state change.
- Output stage: a 1-bit `head_valid` flag marks that RAM `dout` holds the head entry.
- RAM read is issued (`re`=1, `raddr`=rd_ptr[DEPTH_WIDTH-1:0]) when the stage can load, i.e. `!head_valid` or a read is accepted, and one of the following holds:
  - the RAM holds unfetched entries, or
  - a write is accepted this cycle.
- On issue, rd_ptr increments and `head_valid` is set the next cycle. Otherwise an accepted read clears `head_valid`.
- Same-address write/read in one cycle is legal and relies on the RAM bypass, which must be instantiated with bypass enabled.
- `RAM dout` holds its value while `re`=0, so the head stays stable without a read.
- `empty_o` = `!head_valid`.
- `count_o` = entries written but not yet popped, including the head. It is +1 on write only, −1 on read only, and unchanged on simultaneous write and read.
- `full_o` = (`count_o` == 2^DEPTH_WIDTH).
- Simultaneous write and read while full: the read is accepted and the write is rejected, because `full_o` is sampled in the same cycle. The producer must retry.
- Simultaneous write and read while count=1: both are accepted. The new entry becomes the head on the next cycle with no bubble.
- Reset: pointers = 0, `head_valid` = 0, count = 0. Resulting outputs: `empty_o`=1, `full_o`=0, `count_o`=0. `rd_data_o` is don't-care while empty.
- Reset mid-operation discards all contents. RAM contents are not cleared.

## Timing
- Write-to-visible latency is 1 cycle. A write accepted in cycle t into an empty FIFO gives `empty_o`=0 and `rd_data_o`=that data in cycle t+1.
- Read-to-next-head latency is 0 bubbles. A pop in cycle t presents the next entry in cycle t+1 if the FIFO holds ≥2 entries.
- Sustained throughput is one write and one read per cycle.
- All outputs are registered or derived from registers; there are no combinational paths from `wr_i` or `rd_i` to any output.
- `count_o` and `full_o` update on the edge that accepts the transfer.
- `full_o` deasserts the cycle after a pop from full.

## Structure
- No shared package entries. The depth constant is local (`localparam DEPTH = 1<<DEPTH_WIDTH`).
- One sub-module: `mor1kx_simple_dpram_sclk` with `ADDR_WIDTH=DEPTH_WIDTH`, `DATA_WIDTH=DATA_WIDTH`, `ENABLE_BYPASS=1`, `CLEAR_ON_INIT=0`.
- The FIFO block owns only the pointers, the count and `head_valid`. It holds no data storage of its own.
- Formal properties to include:
  - `count_o` ≤ DEPTH.
  - `empty_o` implies `count_o`==0.
  - `$stable(rd_data_o)` when the previous cycle had no accepted read and `head_valid` was set.

## Test plan
- Reset, then write 0xA5A5_0001 in cycle 1 → cycle 2: `empty_o`=0, `rd_data_o`=0xA5A5_0001, `count_o`=1.
- Fill with 16 writes of 0..15 with `rd_i`=0 → `full_o`=1 and `count_o`=16 after the 16th; a 17th write of 0xDEAD is dropped. Popping 16 returns 0..15 in order, then `empty_o`=1.
- With count=1, assert `wr_i` and `rd_i` in the same cycle (data 7, head 6) → head 6 is popped, the next cycle shows `rd_data_o`=7, `count_o`=1.
- While full, assert `wr_i` and `rd_i` together → read accepted, write rejected, `count_o`=15, `full_o`=0 next cycle.
- Stream 100 writes and reads each cycle with the pointers wrapping several times → output order matches input exactly, `count_o` stays constant, no `empty_o` bubble.
- Assert `rst` with count=9 → next cycle `empty_o`=1, `count_o`=0, `full_o`=0. A subsequent write is visible after 1 cycle.
